// File: rtl/lcd_byte_writer_pkg.sv
// Shared constants for the MiniAlu LCD write path: controller commands,
// init nibbles, default 50 MHz timing, FSM encodings and small lookup helpers.
package lcd_byte_writer_pkg;

   localparam int CNT_W = 20;

   localparam logic [7:0] LCD_FUNC_SET = 8'h28;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;

   localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
   localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

   localparam int unsigned DEF_POWERON    = 750000;
   localparam int unsigned DEF_WAIT_4MS   = 205000;
   localparam int unsigned DEF_WAIT_100US = 5000;
   localparam int unsigned DEF_WAIT_40US  = 2000;
   localparam int unsigned DEF_WAIT_CLEAR = 82000;
   localparam int unsigned DEF_SETUP      = 2;
   localparam int unsigned DEF_EN_PULSE   = 12;
   localparam int unsigned DEF_NIBBLE_GAP = 50;

   localparam logic [2:0] ST_POWERON  = 3'd0;
   localparam logic [2:0] ST_INIT_NIB = 3'd1;
   localparam logic [2:0] ST_CFG_BYTE = 3'd2;
   localparam logic [2:0] ST_IDLE     = 3'd3;
   localparam logic [2:0] ST_WR_BYTE  = 3'd4;

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_SETUP = 2'd1;
   localparam logic [1:0] PH_PULSE = 2'd2;
   localparam logic [1:0] PH_WAIT  = 2'd3;

   // Configuration bytes in the order they are sent after the nibble wake-up.
   function automatic logic [7:0] cfgByte(input logic [1:0] idx);
      case (idx)
         2'd0:    return LCD_FUNC_SET;
         2'd1:    return LCD_ENTRY;
         2'd2:    return LCD_DISP_ON;
         default: return LCD_CLEAR;
      endcase
   endfunction

   // Wake-up nibbles: three 0x3 followed by 0x2 to enter 4-bit mode.
   function automatic logic [3:0] initNib(input logic [1:0] idx);
      return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
   endfunction

endpackage

// File: rtl/lcd_byte_writer_strobe.sv
// One enable-strobed nibble on the LCD bus: setup, E pulse, post-wait.
// oDone is high in the last wait cycle so a new start can follow with no gap.
// P_SETUP and P_EN_PULSE must be at least 1.
module lcd_nibble_strobe
   import lcd_byte_writer_pkg::*;
#(
   parameter int unsigned P_SETUP    = DEF_SETUP,
   parameter int unsigned P_EN_PULSE = DEF_EN_PULSE
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iStart,
   input  logic [3:0]       iNibble,
   input  logic             iRS,
   input  logic [CNT_W-1:0] iWaitCycles,
   output logic             oEnabled,
   output logic             oRS,
   output logic [3:0]       oData,
   output logic             oDone
);

   localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(P_SETUP - 1);
   localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(P_EN_PULSE - 1);

   logic [1:0]       phase;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] waitTc;
   logic             accept;

   assign oDone  = (phase == PH_WAIT) && (cnt == '0);
   assign accept = iStart && ((phase == PH_IDLE) || oDone);

   // Phase sequencer; data/RS only load on accept, which is never inside a pulse.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         phase    <= PH_IDLE;
         cnt      <= '0;
         waitTc   <= '0;
         oEnabled <= 1'b0;
         oRS      <= 1'b0;
         oData    <= '0;
      end else if (accept) begin
         phase  <= PH_SETUP;
         cnt    <= SETUP_TC;
         oData  <= iNibble;
         oRS    <= iRS;
         waitTc <= (iWaitCycles == '0) ? '0 : iWaitCycles - 1'b1;
      end else begin
         case (phase)
            PH_SETUP:
               if (cnt == '0) begin
                  phase    <= PH_PULSE;
                  cnt      <= PULSE_TC;
                  oEnabled <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            PH_PULSE:
               if (cnt == '0) begin
                  phase    <= PH_WAIT;
                  cnt      <= waitTc;
                  oEnabled <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            PH_WAIT:
               if (cnt == '0) begin
                  phase <= PH_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            default: phase <= PH_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_byte_writer.sv
// LCD byte writer: power-on init of a 4-bit character LCD, then writes ALU
// bytes accepted over ready/valid as two nibbles, high nibble first.
//
// state       | meaning
// ST_POWERON  | power-on delay before any bus activity
// ST_INIT_NIB | single wake-up nibbles 3,3,3,2 (RS=0)
// ST_CFG_BYTE | configuration bytes 28,06,0C,01 (RS=0)
// ST_IDLE     | ready for a user byte
// ST_WR_BYTE  | sending a user byte (RS=1)
module lcd_byte_writer
   import lcd_byte_writer_pkg::*;
#(
   parameter int unsigned P_POWERON    = DEF_POWERON,
   parameter int unsigned P_WAIT_4MS   = DEF_WAIT_4MS,
   parameter int unsigned P_WAIT_100US = DEF_WAIT_100US,
   parameter int unsigned P_WAIT_40US  = DEF_WAIT_40US,
   parameter int unsigned P_WAIT_CLEAR = DEF_WAIT_CLEAR,
   parameter int unsigned P_SETUP      = DEF_SETUP,
   parameter int unsigned P_EN_PULSE   = DEF_EN_PULSE,
   parameter int unsigned P_NIBBLE_GAP = DEF_NIBBLE_GAP
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iData,
   input  logic       iData_Ready,
   output logic       oReadyForData,
   output logic       oLCD_Enabled,
   output logic       oLCD_RegisterSelect,
   output logic       oLCD_StrataFlashControl,
   output logic       oLCD_ReadWrite,
   output logic [3:0] oLCD_Data
);

   localparam logic [CNT_W-1:0] PWR_TC  = CNT_W'(P_POWERON - 1);
   localparam logic [CNT_W-1:0] W_4MS   = CNT_W'(P_WAIT_4MS);
   localparam logic [CNT_W-1:0] W_100US = CNT_W'(P_WAIT_100US);
   localparam logic [CNT_W-1:0] W_40US  = CNT_W'(P_WAIT_40US);
   localparam logic [CNT_W-1:0] W_CLEAR = CNT_W'(P_WAIT_CLEAR);
   localparam logic [CNT_W-1:0] W_GAP   = CNT_W'(P_NIBBLE_GAP);

   logic [2:0]       state;
   logic [1:0]       stepIdx;
   logic             loNib;
   logic             pendingStart;
   logic [7:0]       byteReg;
   logic [CNT_W-1:0] pwrCnt;
   logic             pwrDone;
   logic             strobeDone;
   logic             start;
   logic             startRs;
   logic [3:0]       startNib;
   logic [CNT_W-1:0] startWait;
   logic [7:0]       curCfg;
   logic [7:0]       nextCfg;

   function automatic logic [CNT_W-1:0] initWait(input logic [1:0] idx);
      case (idx)
         2'd0:    return W_4MS;
         2'd1:    return W_100US;
         default: return W_40US;
      endcase
   endfunction

   assign pwrDone                 = (state == ST_POWERON) && (pwrCnt == PWR_TC);
   assign oReadyForData           = (state == ST_IDLE);
   assign oLCD_StrataFlashControl = 1'b1;
   assign oLCD_ReadWrite          = 1'b0;
   assign curCfg                  = cfgByte(stepIdx);
   // Wraps 3 -> 0, so the last wake-up nibble chains straight into the first config byte.
   assign nextCfg                 = cfgByte(stepIdx + 2'd1);

   // Pick the next nibble to launch; launches coincide with the strobe's done cycle.
   always_comb begin
      start     = 1'b0;
      startRs   = 1'b0;
      startNib  = '0;
      startWait = '0;
      case (state)
         ST_POWERON:
            if (pwrDone) begin
               start     = 1'b1;
               startNib  = initNib(2'd0);
               startWait = initWait(2'd0);
            end
         ST_INIT_NIB:
            if (strobeDone) begin
               start = 1'b1;
               if (stepIdx != 2'd3) begin
                  startNib  = initNib(stepIdx + 2'd1);
                  startWait = initWait(stepIdx + 2'd1);
               end else begin
                  startNib  = nextCfg[7:4];
                  startWait = W_GAP;
               end
            end
         ST_CFG_BYTE:
            if (strobeDone) begin
               if (!loNib) begin
                  start     = 1'b1;
                  startNib  = curCfg[3:0];
                  startWait = (curCfg == LCD_CLEAR) ? W_CLEAR : W_40US;
               end else if (stepIdx != 2'd3) begin
                  start     = 1'b1;
                  startNib  = nextCfg[7:4];
                  startWait = W_GAP;
               end
            end
         ST_WR_BYTE: begin
            startRs = 1'b1;
            if (pendingStart) begin
               start     = 1'b1;
               startNib  = byteReg[7:4];
               startWait = W_GAP;
            end else if (strobeDone && !loNib) begin
               start     = 1'b1;
               startNib  = byteReg[3:0];
               startWait = W_40US;
            end
         end
         default: ;
      endcase
   end

   // Top-level sequencing; the power-on counter stops at its terminal count.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state        <= ST_POWERON;
         stepIdx      <= '0;
         loNib        <= 1'b0;
         pendingStart <= 1'b0;
         byteReg      <= '0;
         pwrCnt       <= '0;
      end else begin
         pendingStart <= 1'b0;
         case (state)
            ST_POWERON:
               if (pwrDone) begin
                  state   <= ST_INIT_NIB;
                  stepIdx <= '0;
               end else begin
                  pwrCnt <= pwrCnt + 1'b1;
               end
            ST_INIT_NIB:
               if (strobeDone) begin
                  stepIdx <= stepIdx + 2'd1;
                  loNib   <= 1'b0;
                  if (stepIdx == 2'd3) state <= ST_CFG_BYTE;
               end
            ST_CFG_BYTE:
               if (strobeDone) begin
                  if (!loNib) begin
                     loNib <= 1'b1;
                  end else begin
                     loNib   <= 1'b0;
                     stepIdx <= stepIdx + 2'd1;
                     if (stepIdx == 2'd3) state <= ST_IDLE;
                  end
               end
            ST_IDLE:
               if (iData_Ready) begin
                  byteReg      <= iData;
                  loNib        <= 1'b0;
                  pendingStart <= 1'b1;
                  state        <= ST_WR_BYTE;
               end
            ST_WR_BYTE:
               if (strobeDone) begin
                  if (!loNib) loNib <= 1'b1;
                  else        state <= ST_IDLE;
               end
            default: state <= ST_POWERON;
         endcase
      end
   end

   lcd_nibble_strobe #(
      .P_SETUP    (P_SETUP),
      .P_EN_PULSE (P_EN_PULSE)
   ) u_strobe (
      .Clock       (Clock),
      .Reset       (Reset),
      .iStart      (start),
      .iNibble     (startNib),
      .iRS         (startRs),
      .iWaitCycles (startWait),
      .oEnabled    (oLCD_Enabled),
      .oRS         (oLCD_RegisterSelect),
      .oData       (oLCD_Data),
      .oDone       (strobeDone)
   );

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer with scaled timing.
// Expected bus nibbles are queued as stimulus is driven; a bus monitor pops
// and compares them on every E rise and checks pulse width and bus stability.
module tb_lcd_byte_writer;

   logic       Clock;
   logic       Reset;
   logic [7:0] iData;
   logic       iData_Ready;
   logic       oReadyForData;
   logic       oLCD_Enabled;
   logic       oLCD_RegisterSelect;
   logic       oLCD_StrataFlashControl;
   logic       oLCD_ReadWrite;
   logic [3:0] oLCD_Data;

   int checks = 0;
   int errors = 0;
   int strobeCount = 0;
   logic [4:0] expQ[$];

   lcd_byte_writer #(
      .P_POWERON    (20),
      .P_WAIT_4MS   (30),
      .P_WAIT_100US (10),
      .P_WAIT_40US  (8),
      .P_WAIT_CLEAR (15),
      .P_SETUP      (2),
      .P_EN_PULSE   (3),
      .P_NIBBLE_GAP (4)
   ) dut (
      .Clock                   (Clock),
      .Reset                   (Reset),
      .iData                   (iData),
      .iData_Ready             (iData_Ready),
      .oReadyForData           (oReadyForData),
      .oLCD_Enabled            (oLCD_Enabled),
      .oLCD_RegisterSelect     (oLCD_RegisterSelect),
      .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
      .oLCD_ReadWrite          (oLCD_ReadWrite),
      .oLCD_Data               (oLCD_Data)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   // Bus monitor: scoreboard pop on E rise, pulse width, stability, tie-offs.
   initial begin
      logic       prevE;
      logic [3:0] prevData;
      logic       prevRs;
      int         highRun;
      logic [4:0] exp;
      prevE = 1'b0; prevData = '0; prevRs = 1'b0; highRun = 0;
      forever begin
         @(negedge Clock);
         checks++;
         if (oLCD_ReadWrite !== 1'b0 || oLCD_StrataFlashControl !== 1'b1) begin
            errors++;
            $display("FAIL tie_off rw=%0b sf=%0b required rw=0 sf=1", oLCD_ReadWrite, oLCD_StrataFlashControl);
         end
         if (!Reset) begin
            prevE = 1'b0; prevData = oLCD_Data; prevRs = oLCD_RegisterSelect; highRun = 0;
         end else begin
            if (oLCD_Enabled || prevE) begin
               checks++;
               if (oLCD_Data !== prevData || oLCD_RegisterSelect !== prevRs) begin
                  errors++;
                  $display("FAIL bus_stable at %0t data %0h->%0h rs %0b->%0b while E high or falling", $time, prevData, oLCD_Data, prevRs, oLCD_RegisterSelect);
               end
            end
            if (oLCD_Enabled && !prevE) begin
               strobeCount++;
               checks++;
               if (expQ.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_strobe at %0t got rs=%0b data=%0h required no strobe", $time, oLCD_RegisterSelect, oLCD_Data);
               end else begin
                  exp = expQ.pop_front();
                  if ({oLCD_RegisterSelect, oLCD_Data} !== exp) begin
                     errors++;
                     $display("FAIL nibble at %0t got rs=%0b data=%0h required rs=%0b data=%0h", $time, oLCD_RegisterSelect, oLCD_Data, exp[4], exp[3:0]);
                  end
               end
            end
            if (oLCD_Enabled) begin
               highRun++;
            end else if (prevE) begin
               checks++;
               if (highRun != 3) begin
                  errors++;
                  $display("FAIL pulse_width at %0t got %0d required 3", $time, highRun);
               end
               highRun = 0;
            end
            prevE = oLCD_Enabled; prevData = oLCD_Data; prevRs = oLCD_RegisterSelect;
         end
      end
   end

   task automatic push_init_seq();
      expQ.push_back({1'b0, 4'h3}); expQ.push_back({1'b0, 4'h3});
      expQ.push_back({1'b0, 4'h3}); expQ.push_back({1'b0, 4'h2});
      expQ.push_back({1'b0, 4'h2}); expQ.push_back({1'b0, 4'h8});
      expQ.push_back({1'b0, 4'h0}); expQ.push_back({1'b0, 4'h6});
      expQ.push_back({1'b0, 4'h0}); expQ.push_back({1'b0, 4'hC});
      expQ.push_back({1'b0, 4'h0}); expQ.push_back({1'b0, 4'h1});
   endtask

   // Counts low-E cycles from reset release (done just after a posedge) to the first E high.
   task automatic measure_poweron(output int n);
      n = 0;
      @(negedge Clock);
      while (!oLCD_Enabled && n < 500) begin
         n++;
         @(negedge Clock);
      end
   endtask

   task automatic wait_ready(input int maxC, output int n);
      n = 0;
      while (!oReadyForData && n < maxC) begin
         @(negedge Clock);
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      #1;
      checks++;
      if ({oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oReadyForData} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got E=%0b RS=%0b D=%0h rdy=%0b required all 0", oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oReadyForData);
      end
      checks++;
      if (oLCD_StrataFlashControl !== 1'b1 || oLCD_ReadWrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_ties got sf=%0b rw=%0b required sf=1 rw=0", oLCD_StrataFlashControl, oLCD_ReadWrite);
      end
      push_init_seq();
      repeat (3) @(negedge Clock);
      @(posedge Clock);
      #1 Reset = 1'b1;
      measure_poweron(n);
      checks++;
      if (n != 22) begin
         errors++;
         $display("FAIL poweron_latency got %0d required 22", n);
      end
   endtask

   task automatic test_init_sequence();
      int n, lowRun;
      n = 0; lowRun = 0;
      while (!oReadyForData && n < 2000) begin
         @(negedge Clock);
         n++;
         if (oLCD_Enabled) lowRun = 0;
         else if (!oReadyForData) lowRun++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL init_timeout got ready=%0b required 1", oReadyForData);
      end
      checks++;
      if (lowRun != 15) begin
         errors++;
         $display("FAIL clear_wait got %0d required 15", lowRun);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL init_nibbles_left got %0d required 0", expQ.size());
      end
   endtask

   task automatic test_single_byte();
      int n, busy, lat;
      logic seenE;
      wait_ready(200, n);
      iData = 8'h41; iData_Ready = 1'b1;
      expQ.push_back({1'b1, 4'h4}); expQ.push_back({1'b1, 4'h1});
      @(negedge Clock);
      iData_Ready = 1'b0;
      busy = 0; lat = 0; seenE = 1'b0;
      while (!oReadyForData && busy < 200) begin
         busy++;
         if (oLCD_Enabled) seenE = 1'b1;
         else if (!seenE) lat++;
         @(negedge Clock);
      end
      checks++;
      if (busy != 23) begin
         errors++;
         $display("FAIL byte_busy_cycles got %0d required 23", busy);
      end
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL accept_to_E got %0d required 3", lat);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL byte_nibbles_left got %0d required 0", expQ.size());
      end
   endtask

   task automatic test_back_to_back();
      int n, s0, readyRun;
      wait_ready(200, n);
      s0 = strobeCount;
      iData = 8'h48; iData_Ready = 1'b1;
      expQ.push_back({1'b1, 4'h4}); expQ.push_back({1'b1, 4'h8});
      @(negedge Clock);
      checks++;
      if (oReadyForData !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first_accept got ready=%0b required 0", oReadyForData);
      end
      iData = 8'h49;
      expQ.push_back({1'b1, 4'h4}); expQ.push_back({1'b1, 4'h9});
      wait_ready(200, n);
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL b2b_timeout got ready=%0b required 1", oReadyForData);
      end
      readyRun = 0;
      while (oReadyForData && readyRun < 10) begin
         readyRun++;
         @(negedge Clock);
      end
      iData_Ready = 1'b0;
      checks++;
      if (readyRun != 1) begin
         errors++;
         $display("FAIL b2b_ready_window got %0d required 1", readyRun);
      end
      wait_ready(200, n);
      repeat (10) @(negedge Clock);
      checks++;
      if (strobeCount - s0 != 4) begin
         errors++;
         $display("FAIL b2b_strobes got %0d required 4", strobeCount - s0);
      end
      checks++;
      if (expQ.size() != 0 || oReadyForData !== 1'b1) begin
         errors++;
         $display("FAIL b2b_end got left=%0d ready=%0b required left=0 ready=1", expQ.size(), oReadyForData);
      end
   endtask

   task automatic test_busy_ignore();
      int n, s0;
      wait_ready(200, n);
      s0 = strobeCount;
      iData = 8'h5A; iData_Ready = 1'b1;
      expQ.push_back({1'b1, 4'h5}); expQ.push_back({1'b1, 4'hA});
      @(negedge Clock);
      iData_Ready = 1'b0;
      n = 0;
      while (!oLCD_Enabled && n < 50) begin
         @(negedge Clock);
         n++;
      end
      iData = 8'hFF; iData_Ready = 1'b1;
      @(negedge Clock);
      iData_Ready = 1'b0;
      wait_ready(200, n);
      repeat (10) @(negedge Clock);
      checks++;
      if (strobeCount - s0 != 2) begin
         errors++;
         $display("FAIL busy_strobes got %0d required 2", strobeCount - s0);
      end
      checks++;
      if (expQ.size() != 0 || oReadyForData !== 1'b1) begin
         errors++;
         $display("FAIL busy_end got left=%0d ready=%0b required left=0 ready=1", expQ.size(), oReadyForData);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int n;
      wait_ready(200, n);
      iData = 8'h37; iData_Ready = 1'b1;
      expQ.push_back({1'b1, 4'h3}); expQ.push_back({1'b1, 4'h7});
      @(negedge Clock);
      iData_Ready = 1'b0;
      n = 0;
      while (!oLCD_Enabled && n < 50) begin
         @(negedge Clock);
         n++;
      end
      #1 Reset = 1'b0;
      #1;
      checks++;
      if ({oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oReadyForData} !== 7'b0) begin
         errors++;
         $display("FAIL async_reset got E=%0b RS=%0b D=%0h rdy=%0b required all 0", oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oReadyForData);
      end
      expQ.delete();
      push_init_seq();
      repeat (2) @(negedge Clock);
      @(posedge Clock);
      #1 Reset = 1'b1;
      measure_poweron(n);
      checks++;
      if (n != 22) begin
         errors++;
         $display("FAIL restart_poweron got %0d required 22", n);
      end
      wait_ready(2000, n);
      checks++;
      if (oReadyForData !== 1'b1 || expQ.size() != 0) begin
         errors++;
         $display("FAIL restart_init got ready=%0b left=%0d required ready=1 left=0", oReadyForData, expQ.size());
      end
   endtask

   initial begin
      Reset = 1'b0;
      iData = '0;
      iData_Ready = 1'b0;
      test_reset();
      test_init_sequence();
      test_single_byte();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid_pulse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
